// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
// Imported by the queue top and its FIFO.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } tx_state_e;

  localparam logic [3:0] UART_IDLE_STA = 4'd0;
  localparam int         BYTE_W        = 8;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with registered count/full/empty flags.
// The head entry is read combinationally from the read pointer.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = BYTE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   dropped
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CNT = PW + 1;
  localparam logic [CNT-1:0] FULL_CNT = CNT'(DEPTH);

  logic [W-1:0]   mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT-1:0] count_q, count_d;
  logic           full_q, full_d;
  logic           empty_q, empty_d;
  logic           wr_ok;
  logic           rd_ok;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  always_comb begin
    rd_ok    = pop & ~empty_q;
    wr_ok    = push & (~full_q | rd_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign dout    = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;
  assign dropped = push & ~wr_ok;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter with a send/status handshake.
// A byte stays queued until its frame completes, then it is popped.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              clr_ovf,
  input  logic [3:0]        send_sta,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              send,
  output logic [BYTE_W-1:0] send_data
);

  localparam int FCW = $clog2(DEPTH) + 1;

  tx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] send_data_q, send_data_d;
  logic              ovf_q, ovf_d;
  logic              pop;
  logic              push;
  logic              dropped;
  logic [BYTE_W-1:0] head;
  logic [FCW-1:0]    fifo_cnt;

  assign push = wr_en & ~rst;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .din     (wr_data),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_cnt),
    .dropped (dropped)
  );

  always_comb begin
    state_d     = state_q;
    send_data_d = send_data_q;
    pop         = 1'b0;
    send        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          send_data_d = head;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        send = 1'b1;
        if (send_sta != UART_IDLE_STA) state_d = WAIT;
      end
      WAIT: begin
        if (send_sta == UART_IDLE_STA) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (dropped) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      send_data_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      send_data_q <= send_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign count     = CW'(fifo_cnt);
  assign overflow  = ovf_q;
  assign send_data = send_data_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a 10-state UART model.
// Expected bytes are queued on write and popped as frames start.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_ovf;
  logic [3:0]    send_sta;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          send;
  logic [7:0]    send_data;

  logic          uart_en;
  logic [3:0]    man_sta;
  logic [3:0]    mdl_sta;
  logic [7:0]    sb [$];
  int            n_vec = 0;
  int            n_err = 0;
  int            frames = 0;

  uart_tx_queue #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_ovf   (clr_ovf),
    .send_sta  (send_sta),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .send      (send),
    .send_data (send_data)
  );

  always #5 clk = ~clk;

  assign send_sta = uart_en ? mdl_sta : man_sta;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART model: accept on send, then count 1..10 and return to idle.
  always @(negedge clk) begin
    if (uart_en) begin
      if (mdl_sta != 4'd0) begin
        mdl_sta = (mdl_sta == 4'd10) ? 4'd0 : mdl_sta + 4'd1;
      end else if (send) begin
        frames++;
        if (sb.size() == 0) chk("spurious_frame", {24'h0, send_data}, 32'hFFFF_FFFF);
        else chk("tx_byte", {24'h0, send_data}, {24'h0, sb.pop_front()});
        mdl_sta = 4'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic drain(input int limit);
    logic done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (sb.size() == 0 && mdl_sta == 4'd0 && empty) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("drain_done", {31'h0, done}, 32'd1);
  endtask

  initial begin
    int f0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;
    uart_en = 1'b0;
    man_sta = 4'd0;
    mdl_sta = 4'd0;
    @(negedge clk);
    step();
    chk("rst_send", {31'h0, send}, 32'd0);
    chk("rst_empty", {31'h0, empty}, 32'd1);
    chk("rst_full", {31'h0, full}, 32'd0);
    chk("rst_count", {27'h0, count}, 32'd0);
    chk("rst_ovf", {31'h0, overflow}, 32'd0);
    chk("rst_data", {24'h0, send_data}, 32'h0);
    rst = 1'b0;
    step();

    // Single byte with a hand-driven status line
    wr(8'hA5);
    chk("single_empty_n1", {31'h0, empty}, 32'd0);
    chk("single_send_n1", {31'h0, send}, 32'd0);
    step();
    chk("single_send_n2", {31'h0, send}, 32'd1);
    chk("single_data", {24'h0, send_data}, 32'hA5);
    man_sta = 4'd1;
    step();
    chk("single_wait_send", {31'h0, send}, 32'd0);
    chk("single_wait_count", {27'h0, count}, 32'd1);
    man_sta = 4'd0;
    step();
    chk("single_count", {27'h0, count}, 32'd0);
    chk("single_empty", {31'h0, empty}, 32'd1);

    // Ordering through the UART model
    uart_en = 1'b1;
    f0 = frames;
    for (int i = 1; i <= 3; i++) begin
      sb.push_back(8'(i));
      wr(8'(i));
    end
    drain(200);
    chk("order_frames", 32'(frames - f0), 32'd3);

    // Fill with the UART stalled in ISSUE
    uart_en = 1'b0;
    man_sta = 4'd0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sb.push_back(8'h40 + 8'(i));
      wr(8'h40 + 8'(i));
      if (i == 15) begin
        chk("fill_full", {31'h0, full}, 32'd1);
        chk("fill_count", {27'h0, count}, 32'd16);
        chk("fill_ovf0", {31'h0, overflow}, 32'd0);
      end
    end
    chk("drop_ovf", {31'h0, overflow}, 32'd1);
    chk("drop_count", {27'h0, count}, 32'd16);
    clr_ovf = 1'b1;
    wr(8'hEE);
    chk("ovf_set_wins", {31'h0, overflow}, 32'd1);
    step();
    clr_ovf = 1'b0;
    chk("ovf_clr", {31'h0, overflow}, 32'd0);

    // Write coinciding with the WAIT->IDLE pop while full
    man_sta = 4'd1;
    step();
    chk("fp_send_wait", {31'h0, send}, 32'd0);
    chk("fp_head", {24'h0, send_data}, {24'h0, sb.pop_front()});
    man_sta = 4'd0;
    sb.push_back(8'h99);
    wr(8'h99);
    chk("fp_count", {27'h0, count}, 32'd16);
    chk("fp_full", {31'h0, full}, 32'd1);
    chk("fp_ovf", {31'h0, overflow}, 32'd0);
    uart_en = 1'b1;
    f0 = frames;
    drain(400);
    chk("fp_frames", 32'(frames - f0), 32'd16);
    chk("fp_end_count", {27'h0, count}, 32'd0);

    // Wrap-around stream of 40 bytes
    f0 = frames;
    for (int i = 0; i < 40; i++) begin
      for (int g = 0; g < 100 && full; g++) step();
      sb.push_back(8'(i));
      wr(8'(i));
    end
    drain(800);
    chk("wrap_frames", 32'(frames - f0), 32'd40);
    chk("wrap_ovf", {31'h0, overflow}, 32'd0);

    // Reset with 5 bytes queued and the FSM waiting on a frame
    for (int i = 0; i < 5; i++) begin
      sb.push_back(8'hA0 + 8'(i));
      wr(8'hA0 + 8'(i));
    end
    for (int g = 0; g < 50 && mdl_sta == 4'd0; g++) step();
    step();
    chk("prerst_count", {27'h0, count}, 32'd5);
    chk("prerst_send", {31'h0, send}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_send", {31'h0, send}, 32'd0);
    chk("midrst_count", {27'h0, count}, 32'd0);
    chk("midrst_empty", {31'h0, empty}, 32'd1);
    sb.delete();
    f0 = frames;
    for (int i = 0; i < 60; i++) step();
    chk("midrst_noissue", 32'(frames - f0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
